// File: rtl/hazard_stall_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_stall_controller: LEGv8 stall/bubble/flush/freeze sequencing.       |
// | Optional perf counters under HAZARD_PERF_CNT_EN.                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hazard_stall_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int ZERO_REG    = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IF_ID_RegisterRn1,
  input  logic [4:0]  IF_ID_RegisterRm2,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_RegisterRd,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Bubble,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Flush,
  output logic        pipe_hold,
  output logic        mem_error,
  output logic [31:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    HALT       = 2'd3
  } state_t;

  localparam logic [7:0] c_timeout  = 8'(MEM_TIMEOUT);
  localparam logic [4:0] c_zero_reg = 5'(ZERO_REG);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_next;
  logic       r_mem_error;
  logic       w_set_error;
  logic       w_load_use;
  logic       w_mem_stall;

  assign w_load_use = ID_EX_MemRead && (ID_EX_RegisterRd != c_zero_reg) &&
                      ((ID_EX_RegisterRd == IF_ID_RegisterRn1) ||
                       (ID_EX_RegisterRd == IF_ID_RegisterRm2));
  assign w_mem_stall = dmem_req && !dmem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_wait_cnt  <= 8'd0;
      r_mem_error <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_set_error) begin
        r_mem_error <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_set_error     = 1'b0;
    PCWrite         = 1'b1;
    IF_ID_Write     = 1'b1;
    ID_EX_Bubble    = 1'b0;
    IF_ID_Flush     = 1'b0;
    ID_EX_Flush     = 1'b0;
    EX_MEM_Flush    = 1'b0;
    pipe_hold       = 1'b0;

    case (r_state)
      RUN, LOAD_STALL: begin
        w_next_state = RUN;
        if (w_mem_stall) begin
          PCWrite         = 1'b0;
          IF_ID_Write     = 1'b0;
          pipe_hold       = 1'b1;
          w_wait_cnt_next = 8'd1;
          w_next_state    = MEM_WAIT;
        end else if (branch_taken) begin
          IF_ID_Flush  = 1'b1;
          ID_EX_Flush  = 1'b1;
          EX_MEM_Flush = 1'b1;
        end else if (w_load_use && (r_state == RUN)) begin
          // A second cycle in LOAD_STALL would double-bubble the same load.
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          w_next_state = LOAD_STALL;
        end
      end
      MEM_WAIT: begin
        // Branches seen here are re-presented once the freeze lifts.
        if (dmem_ready) begin
          w_next_state = RUN;
        end else begin
          PCWrite         = 1'b0;
          IF_ID_Write     = 1'b0;
          pipe_hold       = 1'b1;
          w_wait_cnt_next = r_wait_cnt + 8'd1;
          if (w_wait_cnt_next == c_timeout) begin
            w_set_error  = 1'b1;
            w_next_state = HALT;
          end
        end
      end
      default: begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        pipe_hold   = 1'b1;
      end
    endcase

    // Reset overrides hazards still present on the inputs.
    if (!rst_n) begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Bubble = 1'b0;
      IF_ID_Flush  = 1'b0;
      ID_EX_Flush  = 1'b0;
      EX_MEM_Flush = 1'b0;
      pipe_hold    = 1'b0;
    end
  end

  assign mem_error = r_mem_error;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_count;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= 32'd0;
      r_flush_count <= 16'd0;
    end else begin
      if (!PCWrite && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
      if (IF_ID_Flush && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`else
  assign stall_count = 32'd0;
  assign flush_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// Bench for hazard_stall_controller: directed scenarios plus randomized
// traffic against a cycle-level behavioural model.
module tb_hazard_stall_controller;

  localparam int MEM_TIMEOUT = 16;
  localparam int ZERO_REG    = 31;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rn1, rm2, rd;
  logic        mem_read, branch_taken, dmem_req, dmem_ready;
  logic        PCWrite, IF_ID_Write, ID_EX_Bubble;
  logic        IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, pipe_hold, mem_error;
  logic [31:0] stall_count;
  logic [15:0] flush_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit     m_wait, m_halt, m_after, m_err;
  int     m_cnt;
  longint m_stalls, m_flushes;

  logic [7:0] obs;
  assign obs = {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush,
                ID_EX_Flush, EX_MEM_Flush, pipe_hold, mem_error};

  localparam logic [7:0] O_DEF   = 8'hC0;
  localparam logic [7:0] O_BUB   = 8'h20;
  localparam logic [7:0] O_FLUSH = 8'hDC;
  localparam logic [7:0] O_HOLD  = 8'h02;
  localparam logic [7:0] O_HALT  = 8'h03;

  hazard_stall_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .ZERO_REG(ZERO_REG)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_RegisterRn1(rn1), .IF_ID_RegisterRm2(rm2),
    .ID_EX_MemRead(mem_read), .ID_EX_RegisterRd(rd),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Flush(EX_MEM_Flush),
    .pipe_hold(pipe_hold), .mem_error(mem_error),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic bit lu_now();
    return mem_read && (rd != 5'(ZERO_REG)) && (rd == rn1 || rd == rm2);
  endfunction

  function automatic logic [7:0] expect_out();
    if (!rst_n) return O_DEF;
    if (m_halt) return O_HALT;
    if (m_wait) return dmem_ready ? O_DEF : O_HOLD;
    if (dmem_req && !dmem_ready) return O_HOLD;
    if (branch_taken) return O_FLUSH;
    if (lu_now() && !m_after) return O_BUB;
    return O_DEF;
  endfunction

  task automatic idle();
    rn1 = 5'd0; rm2 = 5'd0; rd = 5'd0;
    mem_read = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic clear_model();
    m_wait = 0; m_halt = 0; m_after = 0; m_err = 0; m_cnt = 0;
    m_stalls = 0; m_flushes = 0;
  endtask

  // Advance one clock, updating the model with the inputs held at the edge.
  task automatic tick();
    logic [7:0] e;
    bit lu, ms;
    e  = expect_out();
    lu = lu_now();
    ms = dmem_req && !dmem_ready;
    @(posedge clk);
    if (!e[7] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    if (e[4] && m_flushes < 64'hFFFF) m_flushes++;
    if (m_halt) begin
    end else if (m_wait) begin
      if (dmem_ready) begin
        m_wait = 0; m_after = 0;
      end else begin
        m_cnt++;
        if (m_cnt == MEM_TIMEOUT) begin
          m_halt = 1; m_err = 1; m_wait = 0;
        end
      end
    end else if (ms) begin
      m_wait = 1; m_cnt = 1; m_after = 0;
    end else if (branch_taken) begin
      m_after = 0;
    end else begin
      m_after = lu && !m_after;
    end
    @(negedge clk);
  endtask

  // Called just after a negedge; the pulse stays clear of the rising edge.
  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    #3;
    clear_model();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    mem_read = 1'b1; rd = 5'd3; rn1 = 5'd3; dmem_req = 1'b1;
    #1;
    checks++;
    if (obs !== O_DEF) begin errors++; $display("FAIL reset_outputs obs=%h exp=%h", obs, O_DEF); end
    checks++;
    if (stall_count !== 32'd0 || flush_count !== 16'd0) begin
      errors++; $display("FAIL reset_counters stall=%0d flush=%0d exp=0", stall_count, flush_count);
    end
    @(negedge clk);
    apply_reset();
    #1;
    checks++;
    if (obs !== O_DEF) begin errors++; $display("FAIL reset_release obs=%h exp=%h", obs, O_DEF); end
    tick();
  endtask

  task automatic test_load_use();
    apply_reset();
    mem_read = 1'b1; rd = 5'd5; rn1 = 5'd5; rm2 = 5'd9;
    #1;
    checks++;
    if (obs !== O_BUB) begin errors++; $display("FAIL load_use_bubble obs=%h exp=%h", obs, O_BUB); end
    tick();
    #1;
    checks++;
    if (obs !== O_DEF) begin errors++; $display("FAIL load_use_no_second obs=%h exp=%h", obs, O_DEF); end
    tick();
    idle();
    #1;
    checks++;
    if (obs !== O_DEF) begin errors++; $display("FAIL load_use_after obs=%h exp=%h", obs, O_DEF); end
    tick();
  endtask

  task automatic test_xzr();
    apply_reset();
    mem_read = 1'b1; rd = 5'd31; rn1 = 5'd31; rm2 = 5'd31;
    #1;
    checks++;
    if (obs !== O_DEF) begin errors++; $display("FAIL xzr_no_stall obs=%h exp=%h", obs, O_DEF); end
    tick();
    rd = 5'd7; rn1 = 5'd1; rm2 = 5'd7;
    #1;
    checks++;
    if (obs !== O_BUB) begin errors++; $display("FAIL rm2_stall obs=%h exp=%h", obs, O_BUB); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_branch_vs_load();
    apply_reset();
    mem_read = 1'b1; rd = 5'd5; rn1 = 5'd5; branch_taken = 1'b1;
    #1;
    checks++;
    if (obs !== O_FLUSH) begin errors++; $display("FAIL branch_priority obs=%h exp=%h", obs, O_FLUSH); end
    tick();
    branch_taken = 1'b0;
    #1;
    checks++;
    if (obs !== O_BUB) begin errors++; $display("FAIL branch_then_bubble obs=%h exp=%h", obs, O_BUB); end
    tick();
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (flush_count !== 16'd1 || stall_count !== 32'd1) begin
      errors++; $display("FAIL branch_counters flush=%0d stall=%0d exp=1/1", flush_count, stall_count);
    end
`endif
    idle();
    tick();
  endtask

  task automatic test_mem_wait();
    logic [31:0] s0;
    apply_reset();
    s0 = stall_count;
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs !== O_HOLD) begin errors++; $display("FAIL mem_wait_hold[%0d] obs=%h exp=%h", i, obs, O_HOLD); end
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== O_DEF) begin errors++; $display("FAIL mem_wait_release obs=%h exp=%h", obs, O_DEF); end
    tick();
    idle();
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_count - s0 !== 32'd4) begin
      errors++; $display("FAIL mem_wait_stall_count got=%0d exp=4", stall_count - s0);
    end
`endif
    tick();
  endtask

  task automatic test_timeout();
    apply_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1;
      checks++;
      if (obs !== O_HOLD) begin errors++; $display("FAIL timeout_wait[%0d] obs=%h exp=%h", i, obs, O_HOLD); end
      tick();
    end
    dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== O_HALT) begin errors++; $display("FAIL halt_persist[%0d] obs=%h exp=%h", i, obs, O_HALT); end
      tick();
    end
    apply_reset();
    #1;
    checks++;
    if (obs !== O_DEF) begin errors++; $display("FAIL halt_reset obs=%h exp=%h", obs, O_DEF); end
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== O_DEF) begin errors++; $display("FAIL async_reset_mid_wait obs=%h exp=%h", obs, O_DEF); end
    idle();
    clear_model();
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== O_DEF) begin errors++; $display("FAIL async_reset_release obs=%h exp=%h", obs, O_DEF); end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] regs [5];
    regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd2; regs[3] = 5'd3; regs[4] = 5'd31;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      rn1          = regs[$urandom_range(0, 4)];
      rm2          = regs[$urandom_range(0, 4)];
      rd           = regs[$urandom_range(0, 4)];
      mem_read     = ($urandom_range(0, 1) == 1);
      branch_taken = ($urandom_range(0, 4) == 0);
      dmem_req     = ($urandom_range(0, 3) == 0);
      dmem_ready   = ($urandom_range(0, 1) == 1);
      #1;
      checks++;
      if (obs !== expect_out()) begin
        errors++; $display("FAIL random[%0d] obs=%h exp=%h", i, obs, expect_out());
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_count !== 32'(m_stalls) || flush_count !== 16'(m_flushes)) begin
        errors++;
        $display("FAIL random_counters[%0d] stall=%0d/%0d flush=%0d/%0d", i,
                 stall_count, m_stalls, flush_count, m_flushes);
      end
`endif
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    clear_model();
    test_reset();
    test_load_use();
    test_xzr();
    test_branch_vs_load();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage LEGv8 core; sits beside the forwarding unit and owns every stall, bubble, flush and freeze decision.
- Covers load-use stalls that forwarding cannot resolve, taken-branch flushes, and data-memory wait states with a timeout watchdog.
- Drives PC, IF/ID, ID/EX and EX/MEM write/flush controls; forwarding select generation stays outside this block.

Parameters:
- MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before a fatal halt (range 2..255).
- ZERO_REG, 31, register index that is never a hazard source (XZR).

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- IF_ID_RegisterRn1  in  5  source 1 of the instruction in decode
- IF_ID_RegisterRm2  in  5  source 2 of the instruction in decode
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_RegisterRd  in  5  destination of the instruction in EX
- branch_taken  in  1  resolved taken branch in MEM stage
- dmem_req  in  1  data-memory access active this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- PCWrite  out  1  PC may update
- IF_ID_Write  out  1  IF/ID may load
- ID_EX_Bubble  out  1  zero ID/EX control fields
- IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush  out  1 each  squash stage contents
- pipe_hold  out  1  freeze every pipeline register (including MEM/WB)
- mem_error  out  1  sticky watchdog fault
- stall_count  out  32  stall-cycle counter (optional feature)
- flush_count  out  16  taken-branch flush counter (optional feature)

Behaviour:
- States: RUN, LOAD_STALL, MEM_WAIT, HALT; 2-bit state register, async reset to RUN. Reset clears the wait counter, mem_error and both perf counters.
- Outputs are combinational from state and current inputs. Defaults: PCWrite=1, IF_ID_Write=1; all others 0.
- load_use = ID_EX_MemRead && ID_EX_RegisterRd!=ZERO_REG && (Rd==Rn1 || Rd==Rm2).
- mem_stall = dmem_req && !dmem_ready.
- Priority in RUN and LOAD_STALL is mem_stall > branch_taken > load_use.
- mem_stall: PCWrite=0, IF_ID_Write=0, pipe_hold=1. Load wait counter with 1. Next state is MEM_WAIT.
- branch_taken: IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1. PCWrite=1 so the branch target loads. No bubble. Next state is RUN.
- load_use in RUN: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, for exactly one cycle. Next state is LOAD_STALL.
- LOAD_STALL: load_use is ignored, so there is never a second bubble for the same load. Mem_stall and branch are still honoured. Default next state is RUN.
- MEM_WAIT: hold outputs as for mem_stall, and the counter increments.
  - dmem_ready=1: hold is released in the same cycle; next state is RUN.
  - branch_taken during MEM_WAIT is deferred: the pipeline is frozen, so the branch is re-presented.
  - Counter reaches MEM_TIMEOUT with no ready: mem_error is set; next state is HALT.
- HALT: PCWrite=0, IF_ID_Write=0, pipe_hold=1 permanently; mem_error stays 1. Only rst_n exits HALT.
- Reset asserted mid-stall forces RUN immediately, with outputs at their defaults.
- Counter width is 8 bits; the comparison is equality, so there is no wrap.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - stall_count increments on every cycle with PCWrite=0, saturating at 2^32-1.
  - flush_count increments on every flush cycle, saturating at 2^16-1.
  - Both counters reset asynchronously to 0.
- Not defined: both counter ports are tied to 0 and no counter flops are synthesised.

Test Plan:
- Load-use: ID_EX_MemRead=1, Rd=5, Rn1=5 -> one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, then RUN. Holding the same inputs in LOAD_STALL gives no second bubble.
- No hazard via XZR: ID_EX_MemRead=1, Rd=31, Rn1=31 -> no stall. Rd=7, Rm2=7 -> stall.
- Branch vs load-use in the same cycle: branch_taken=1 and load_use=1 -> the three flushes assert, PCWrite=1, ID_EX_Bubble=0.
- Memory wait: dmem_req=1, dmem_ready=0 for 4 cycles, then 1 -> pipe_hold=1 for 4 cycles and released in the ready cycle. stall_count=4 with HAZARD_PERF_CNT_EN.
- Timeout: ready never returns with MEM_TIMEOUT=16 -> mem_error rises after 16 wait cycles, HALT persists, and rst_n low returns RUN with mem_error=0.
- Async reset: rst_n dropped mid-MEM_WAIT (between clock edges) -> outputs return to defaults immediately.
